// File: rtl/gpr_write_sequencer.sv
// gpr_write_sequencer: decodes a byte-wide instruction stream (LDI / MOV / CLR / NOP)
// and drives one-hot load strobes plus write data into a 4 x 8-bit register bank.
// Optional feature macro: GPR_SEQ_ADD_EN turns opcode 00 from NOP into ADD.
module gpr_write_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] rd0,
    input  logic [7:0] rd1,
    input  logic [7:0] rd2,
    input  logic [7:0] rd3,
    output logic       load0,
    output logic       load1,
    output logic       load2,
    output logic       load3,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic [7:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IMM  = 2'd1,
        EXEC = 2'd2
    } state_t;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_MOV = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_dst;
    logic [3:0] r_load;
    logic [7:0] r_wr_data;
    logic [7:0] r_instr_count;

    logic       w_accept;
    logic [1:0] w_opcode;
    logic [1:0] w_dst;
    logic [1:0] w_src;
    logic [7:0] w_rd_src;
    logic       w_goes_exec;
    logic [7:0] w_idle_data;
    logic       w_unused;

    assign w_opcode = instr[7:6];
    assign w_dst    = instr[5:4];
    assign w_src    = instr[3:2];
    assign w_unused = &{1'b0, instr[1:0]};

    // The sequencer only refuses bytes while a write strobe is on the bus
    assign instr_ready = (r_state != EXEC);
    assign busy        = (r_state != IDLE);
    assign w_accept    = instr_valid & instr_ready;

    assign load0       = r_load[0];
    assign load1       = r_load[1];
    assign load2       = r_load[2];
    assign load3       = r_load[3];
    assign wr_data     = r_wr_data;
    assign instr_count = r_instr_count;

    // Read-port mux selecting the source register for MOV/ADD
    always_comb begin
        w_rd_src = rd0;
        case (w_src)
            2'd0:    w_rd_src = rd0;
            2'd1:    w_rd_src = rd1;
            2'd2:    w_rd_src = rd2;
            default: w_rd_src = rd3;
        endcase
    end

`ifdef GPR_SEQ_ADD_EN
    logic [7:0] w_rd_dst;

    // Read-port mux selecting the destination register as the ADD accumulator
    always_comb begin
        w_rd_dst = rd0;
        case (w_dst)
            2'd0:    w_rd_dst = rd0;
            2'd1:    w_rd_dst = rd1;
            2'd2:    w_rd_dst = rd2;
            default: w_rd_dst = rd3;
        endcase
    end
`endif

    // Single-byte decode: which opcodes write straight away and with what value
    always_comb begin
        w_goes_exec = 1'b0;
        w_idle_data = 8'h00;
        case (w_opcode)
            OP_MOV: begin
                w_goes_exec = 1'b1;
                w_idle_data = w_rd_src;
            end
            OP_CLR: begin
                w_goes_exec = 1'b1;
                w_idle_data = 8'h00;
            end
            OP_NOP: begin
`ifdef GPR_SEQ_ADD_EN
                w_goes_exec = 1'b1;
                w_idle_data = w_rd_dst + w_rd_src;
`else
                w_goes_exec = 1'b0;
                w_idle_data = 8'h00;
`endif
            end
            default: begin
                w_goes_exec = 1'b0;
                w_idle_data = 8'h00;
            end
        endcase
    end

    // State register; reset drops any half-finished instruction immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: LDI waits for its immediate, every write spends one cycle in EXEC
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_opcode == OP_LDI) begin
                        w_next_state = IMM;
                    end else if (w_goes_exec) begin
                        w_next_state = EXEC;
                    end
                end
            end
            IMM: begin
                if (w_accept) begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Registered outputs: strobe and data are set up on entry to EXEC so they are glitch-free
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dst         <= 2'd0;
            r_load        <= 4'b0000;
            r_wr_data     <= 8'h00;
            r_instr_count <= 8'h00;
        end else begin
            r_load <= 4'b0000;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dst <= w_dst;
                        if (w_goes_exec) begin
                            r_wr_data <= w_idle_data;
                            r_load    <= 4'b0001 << w_dst;
                        end
                    end
                end
                IMM: begin
                    if (w_accept) begin
                        r_wr_data <= instr;
                        r_load    <= 4'b0001 << r_dst;
                    end
                end
                EXEC: begin
                    r_instr_count <= r_instr_count + 8'd1;
                end
                default: begin
                    r_load <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpr_write_sequencer.sv
// tb_gpr_write_sequencer: drives instruction streams into gpr_write_sequencer, models the
// register bank it writes, and compares every cycle against an instruction-level reference.
`timescale 1ns/1ps
module tb_gpr_write_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic       load0, load1, load2, load3;
    logic [7:0] wr_data;
    logic       busy;
    logic [7:0] instr_count;
    logic [7:0] bank [4];

    int testsRun = 0;
    int testsFailed = 0;

    // Reference state: register contents, pending immediate, and the write being presented
    bit         mExec;
    int         mDst;
    logic [7:0] mWr;
    logic [7:0] mCount;
    bit         mImmPending;
    int         mImmDst;
    logic [7:0] mRegs [4];

    logic [21:0] obs;
    logic [21:0] exp;
    bit          acc;

    gpr_write_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .rd0         (bank[0]),
        .rd1         (bank[1]),
        .rd2         (bank[2]),
        .rd3         (bank[3]),
        .load0       (load0),
        .load1       (load1),
        .load2       (load2),
        .load3       (load3),
        .wr_data     (wr_data),
        .busy        (busy),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Register bank the sequencer feeds and reads back
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) bank[i] <= 8'h00;
        end else begin
            if (load0) bank[0] <= wr_data;
            if (load1) bank[1] <= wr_data;
            if (load2) bank[2] <= wr_data;
            if (load3) bank[3] <= wr_data;
        end
    end

    function automatic logic [21:0] expectedOutputs();
        logic [3:0] ld;
        ld = mExec ? (4'b0001 << mDst) : 4'b0000;
        return {~mExec, (mExec | mImmPending), ld, mWr, mCount};
    endfunction

    task automatic modelReset();
        mExec = 0; mDst = 0; mWr = 8'h00; mCount = 8'h00;
        mImmPending = 0; mImmDst = 0;
        for (int i = 0; i < 4; i++) mRegs[i] = 8'h00;
    endtask

    // Present one byte for one cycle and advance the reference by the instruction rules
    task automatic applyStimulus(input logic v, input logic [7:0] b, output bit accepted);
        instr = b;
        instr_valid = v;
        accepted = v && !mExec;
        @(posedge clk);
        if (mExec) begin
            mRegs[mDst] = mWr;
            mCount = mCount + 8'd1;
            mExec = 0;
        end else if (accepted) begin
            if (mImmPending) begin
                mWr = b; mDst = mImmDst; mExec = 1; mImmPending = 0;
            end else begin
                case (b[7:6])
                    2'b01: begin mImmPending = 1; mImmDst = int'(b[5:4]); end
                    2'b10: begin mWr = mRegs[b[3:2]]; mDst = int'(b[5:4]); mExec = 1; end
                    2'b11: begin mWr = 8'h00; mDst = int'(b[5:4]); mExec = 1; end
                    default: begin
`ifdef GPR_SEQ_ADD_EN
                        mWr = mRegs[b[5:4]] + mRegs[b[3:2]];
                        mDst = int'(b[5:4]);
                        mExec = 1;
`endif
                    end
                endcase
            end
        end
        @(negedge clk);
    endtask

    task automatic resetDut();
        instr_valid = 1'b0;
        reset = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        modelReset();
        #12;
        obs = {instr_ready, busy, load3, load2, load1, load0, wr_data, instr_count};
        testsRun++;
        if (obs !== 22'h200000) begin
            testsFailed++;
            $display("[TB] FAIL reset_values got %h want %h", obs, 22'h200000);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_ldi();
        logic [7:0] stream [8] = '{8'h40, 8'h03, 8'h50, 8'h05, 8'h60, 8'h06, 8'h70, 8'h09};
        int idx = 0;
        int pulses = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            applyStimulus(1'b1, stream[idx], acc);
            if (acc) idx++;
            obs = {instr_ready, busy, load3, load2, load1, load0, wr_data, instr_count};
            exp = expectedOutputs();
            testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL ldi_cycle%0d got %h want %h", c, obs, exp);
            end
            if ({load3, load2, load1, load0} != 4'b0000) pulses++;
        end
        testsRun++;
        if (idx != 8 || {load3, load2, load1, load0} !== 4'b1000 || wr_data !== 8'h09) begin
            testsFailed++;
            $display("[TB] FAIL ldi_last idx=%0d loads=%b data=%h want idx=8 loads=1000 data=09",
                     idx, {load3, load2, load1, load0}, wr_data);
        end
        testsRun++;
        if (pulses != 4) begin
            testsFailed++;
            $display("[TB] FAIL ldi_pulses got %0d want 4", pulses);
        end
        applyStimulus(1'b0, 8'h00, acc);
        testsRun++;
        if (instr_count !== 8'd4 || bank[0] !== 8'h03 || bank[1] !== 8'h05 ||
            bank[2] !== 8'h06 || bank[3] !== 8'h09) begin
            testsFailed++;
            $display("[TB] FAIL ldi_bank count=%0d r0..3=%h %h %h %h want 4 03 05 06 09",
                     instr_count, bank[0], bank[1], bank[2], bank[3]);
        end
    endtask

    task automatic test_mov_hold();
        applyStimulus(1'b1, 8'hA4, acc);
        testsRun++;
        if ({load3, load2, load1, load0} !== 4'b0100 || wr_data !== 8'h05 || instr_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mov_exec loads=%b data=%h ready=%b want 0100 05 0",
                     {load3, load2, load1, load0}, wr_data, instr_ready);
        end
        applyStimulus(1'b1, 8'hF0, acc);
        testsRun++;
        if ({load3, load2, load1, load0} !== 4'b0000 || instr_ready !== 1'b1 || bank[2] !== 8'h05) begin
            testsFailed++;
            $display("[TB] FAIL mov_hold loads=%b ready=%b r2=%h want 0000 1 05",
                     {load3, load2, load1, load0}, instr_ready, bank[2]);
        end
        applyStimulus(1'b1, 8'hF0, acc);
        testsRun++;
        if ({load3, load2, load1, load0} !== 4'b1000 || wr_data !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL clr_exec loads=%b data=%h want 1000 00", {load3, load2, load1, load0}, wr_data);
        end
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 8'h00, acc);
            obs = {instr_ready, busy, load3, load2, load1, load0, wr_data, instr_count};
            exp = expectedOutputs();
            testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL nop_cycle%0d got %h want %h", c, obs, exp);
            end
        end
`ifndef GPR_SEQ_ADD_EN
        testsRun++;
        if (instr_count !== 8'd6 || {load3, load2, load1, load0} !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL nop_count count=%0d loads=%b want 6 0000", instr_count, {load3, load2, load1, load0});
        end
`endif
    endtask

    task automatic test_reset_abort();
        resetDut();
        applyStimulus(1'b1, 8'h50, acc);
        instr_valid = 1'b0;
        #2 reset = 1'b0;
        modelReset();
        #1;
        obs = {instr_ready, busy, load3, load2, load1, load0, wr_data, instr_count};
        testsRun++;
        if (obs !== 22'h200000) begin
            testsFailed++;
            $display("[TB] FAIL abort_async got %h want %h", obs, 22'h200000);
        end
        @(negedge clk);
        testsRun++;
        if ({load3, load2, load1, load0} !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL abort_noload got %b want 0000", {load3, load2, load1, load0});
        end
        reset = 1'b1;
        applyStimulus(1'b1, 8'hF0, acc);
        testsRun++;
        if ({load3, load2, load1, load0} !== 4'b1000 || wr_data !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL abort_redecode loads=%b data=%h want 1000 00",
                     {load3, load2, load1, load0}, wr_data);
        end
        applyStimulus(1'b0, 8'h00, acc);
    endtask

    task automatic test_wrap();
        int done = 0;
        resetDut();
        for (int c = 0; c < 600 && done < 256; c++) begin
            applyStimulus(1'b1, 8'hF0, acc);
            if (acc) done++;
            obs = {instr_ready, busy, load3, load2, load1, load0, wr_data, instr_count};
            exp = expectedOutputs();
            testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL wrap_cycle%0d got %h want %h", c, obs, exp);
            end
        end
        applyStimulus(1'b0, 8'h00, acc);
        testsRun++;
        if (done != 256 || instr_count !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL wrap_count accepted=%0d count=%h want 256 00", done, instr_count);
        end
    endtask

`ifdef GPR_SEQ_ADD_EN
    task automatic test_add();
        logic [7:0] stream [5] = '{8'h40, 8'hFF, 8'h50, 8'h02, 8'h04};
        int idx = 0;
        resetDut();
        for (int c = 0; c < 30 && idx < 5; c++) begin
            applyStimulus(1'b1, stream[idx], acc);
            if (acc) idx++;
        end
        testsRun++;
        if (idx != 5 || {load3, load2, load1, load0} !== 4'b0001 || wr_data !== 8'h01) begin
            testsFailed++;
            $display("[TB] FAIL add_wrap idx=%0d loads=%b data=%h want 5 0001 01",
                     idx, {load3, load2, load1, load0}, wr_data);
        end
        applyStimulus(1'b0, 8'h00, acc);
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), acc);
            obs = {instr_ready, busy, load3, load2, load1, load0, wr_data, instr_count};
            exp = expectedOutputs();
            testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL random_cycle%0d got %h want %h", c, obs, exp);
            end
        end
        applyStimulus(1'b0, 8'h00, acc);
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if (bank[i] !== mRegs[i]) begin
                testsFailed++;
                $display("[TB] FAIL random_r%0d got %h want %h", i, bank[i], mRegs[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_mov_hold();
        test_reset_abort();
        test_wrap();
`ifdef GPR_SEQ_ADD_EN
        test_add();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
